// File: rtl/sa_ram_fifo_ctrl_512x512_pkg.sv
// Shared sizing for the SA RAM FIFO controller and its output buffer.
package sa_ram_fifo_ctrl_512x512_pkg;

  localparam int SA_RAM_DW    = 512;
  localparam int SA_RAM_AW    = 9;
  localparam int SA_RAM_DEPTH = 512;

  // Output buffer holds captured RAM words; two entries cover the RAM read latency.
  localparam int SA_OBUF_ENTRIES = 2;

  typedef logic [1:0] ob_cnt_t;

endpackage

// File: rtl/sa_ram_fifo_ctrl_512x512_obuf.sv
// Two-entry circular output buffer: captures RAM read data, presents it valid/ready.
module sa_ram_fifo_obuf
  import sa_ram_fifo_ctrl_512x512_pkg::*;
#(
  parameter int DW = SA_RAM_DW
) (
  input  logic          i_clk,
  input  logic          i_rstn,
  input  logic          i_cap,
  input  logic [DW-1:0] i_cap_pd,
  input  logic          i_rdy,
  output logic          o_vld,
  output logic [DW-1:0] o_pd,
  output ob_cnt_t       o_cnt,
  output logic          o_pop
);

  logic [DW-1:0] r_mem [SA_OBUF_ENTRIES];
  logic          r_wi;
  logic          r_ri;
  ob_cnt_t       r_cnt;
  logic          w_pop;

  assign o_vld = (r_cnt != 2'd0);
  assign w_pop = o_vld & i_rdy;
  assign o_pd  = r_mem[r_ri];
  assign o_cnt = r_cnt;
  assign o_pop = w_pop;

  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      r_wi  <= 1'b0;
      r_ri  <= 1'b0;
      r_cnt <= 2'd0;
    end else begin
      if (i_cap) r_wi <= ~r_wi;
      if (w_pop) r_ri <= ~r_ri;
      case ({i_cap, w_pop})
        2'b10:   r_cnt <= r_cnt + 2'd1;
        2'b01:   r_cnt <= r_cnt - 2'd1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  // Data storage needs no reset; an entry is only observed after it is captured.
  always_ff @(posedge i_clk) begin
    if (i_cap) r_mem[r_wi] <= i_cap_pd;
  end

`ifndef SYNTHESIS
  a_head_hold: assert property (@(posedge i_clk) disable iff (!i_rstn)
    (o_vld && !i_rdy) |=> (o_vld && $stable(o_pd)));
`endif

endmodule

// File: rtl/sa_ram_fifo_ctrl_512x512.sv
// Valid/ready FIFO wrapper around an external 512x512 two-port SA RAM.
module sa_ram_fifo_ctrl_512x512
  import sa_ram_fifo_ctrl_512x512_pkg::*;
#(
  parameter int DW    = SA_RAM_DW,
  parameter int AW    = SA_RAM_AW,
  parameter int DEPTH = SA_RAM_DEPTH
) (
  input  logic          nvdla_core_clk,
  input  logic          nvdla_core_rstn,
  input  logic          wr_pvld,
  output logic          wr_prdy,
  input  logic [DW-1:0] wr_pd,
  output logic          rd_pvld,
  input  logic          rd_prdy,
  output logic [DW-1:0] rd_pd,
  output logic [AW-1:0] ram_wa,
  output logic          ram_we,
  output logic [DW-1:0] ram_di,
  output logic [AW-1:0] ram_ra,
  output logic          ram_re,
  input  logic [DW-1:0] ram_dout,
  output logic          fifo_idle
);

  // Handshake: a word moves on a side in every cycle where valid and ready are both
  // high at the rising edge; a producer holding valid with ready low must keep its
  // data stable, and rd_pd is held stable by this block while rd_pvld=1, rd_prdy=0.

  localparam logic [AW:0] L_DEPTH = (AW+1)'(DEPTH);

  logic          r_rstn_q;
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [AW:0]   r_ram_cnt;
  logic          r_inflight;

  logic          w_wr_acc;
  logic          w_rd_pop;
  logic          w_ram_re;
  logic [AW:0]   w_ram_cnt_nxt;
  ob_cnt_t       w_ob_cnt;
  logic [2:0]    w_ob_occ;
  logic [2:0]    w_ob_occ_after;
  logic          w_ob_vld;
  logic [DW-1:0] w_ob_pd;

  assign wr_prdy  = r_rstn_q & (r_ram_cnt != L_DEPTH);
  assign w_wr_acc = wr_pvld & wr_prdy;

  assign ram_we = w_wr_acc;
  assign ram_wa = r_wptr;
  assign ram_di = wr_pd;

  // Issue a read only if the buffer still has room once in-flight data lands and
  // this cycle's pop leaves. The current-cycle write is not in r_ram_cnt yet.
  assign w_ob_occ       = {1'b0, w_ob_cnt} + {2'b00, r_inflight};
  assign w_ob_occ_after = w_ob_occ - {2'b00, w_rd_pop};
  assign w_ram_re       = (r_ram_cnt != '0) && (w_ob_occ_after < 3'd2);

  assign ram_re = w_ram_re;
  assign ram_ra = r_rptr;

  always_comb begin
    w_ram_cnt_nxt = r_ram_cnt;
    case ({w_wr_acc, w_ram_re})
      2'b10:   w_ram_cnt_nxt = r_ram_cnt + (AW+1)'(1);
      2'b01:   w_ram_cnt_nxt = r_ram_cnt - (AW+1)'(1);
      default: w_ram_cnt_nxt = r_ram_cnt;
    endcase
  end

  always_ff @(posedge nvdla_core_clk) begin
    if (!nvdla_core_rstn) begin
      r_rstn_q   <= 1'b0;
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_ram_cnt  <= '0;
      r_inflight <= 1'b0;
    end else begin
      r_rstn_q   <= 1'b1;
      if (w_wr_acc) r_wptr <= r_wptr + AW'(1);
      if (w_ram_re) r_rptr <= r_rptr + AW'(1);
      r_ram_cnt  <= w_ram_cnt_nxt;
      r_inflight <= w_ram_re;
    end
  end

  // ram_dout is only meaningful the cycle after ram_re; r_inflight marks that cycle.
  sa_ram_fifo_obuf #(
    .DW (DW)
  ) u_obuf (
    .i_clk    (nvdla_core_clk),
    .i_rstn   (nvdla_core_rstn),
    .i_cap    (r_inflight),
    .i_cap_pd (ram_dout),
    .i_rdy    (rd_prdy),
    .o_vld    (w_ob_vld),
    .o_pd     (w_ob_pd),
    .o_cnt    (w_ob_cnt),
    .o_pop    (w_rd_pop)
  );

  assign rd_pvld = w_ob_vld;
  assign rd_pd   = w_ob_pd;

  assign fifo_idle = (r_ram_cnt == '0) & ~r_inflight & (w_ob_cnt == 2'd0);

`ifndef SYNTHESIS
  a_wr_hold: assert property (@(posedge nvdla_core_clk) disable iff (!nvdla_core_rstn)
    (wr_pvld && !wr_prdy) |=> (wr_pvld && $stable(wr_pd)));
  a_ob_bound: assert property (@(posedge nvdla_core_clk) disable iff (!nvdla_core_rstn)
    (w_ob_occ <= 3'd2));
  a_no_re_empty: assert property (@(posedge nvdla_core_clk) disable iff (!nvdla_core_rstn)
    (r_ram_cnt == '0) |-> !w_ram_re);
  a_cnt_range: assert property (@(posedge nvdla_core_clk) disable iff (!nvdla_core_rstn)
    (r_ram_cnt <= L_DEPTH));
`endif

endmodule

// File: tb/tb_sa_ram_fifo_ctrl_512x512.sv
// Bench for sa_ram_fifo_ctrl_512x512: RAM model, queue scoreboard, directed + random steps.
module tb_sa_ram_fifo_ctrl_512x512;
  import sa_ram_fifo_ctrl_512x512_pkg::*;

  localparam int DW    = SA_RAM_DW;
  localparam int AW    = SA_RAM_AW;
  localparam int DEPTH = SA_RAM_DEPTH;
  localparam logic [DW-1:0] JUNK = {16{32'hDEAD_BEEF}};

  // ---------------- clock / reset ----------------
  logic clk;
  logic rstn;
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  logic          wr_pvld, wr_prdy, rd_pvld, rd_prdy;
  logic [DW-1:0] wr_pd, rd_pd, ram_di, ram_dout;
  logic [AW-1:0] ram_wa, ram_ra;
  logic          ram_we, ram_re, fifo_idle;

  sa_ram_fifo_ctrl_512x512 dut (
    .nvdla_core_clk  (clk),
    .nvdla_core_rstn (rstn),
    .wr_pvld         (wr_pvld),
    .wr_prdy         (wr_prdy),
    .wr_pd           (wr_pd),
    .rd_pvld         (rd_pvld),
    .rd_prdy         (rd_prdy),
    .rd_pd           (rd_pd),
    .ram_wa          (ram_wa),
    .ram_we          (ram_we),
    .ram_di          (ram_di),
    .ram_ra          (ram_ra),
    .ram_re          (ram_re),
    .ram_dout        (ram_dout),
    .fifo_idle       (fifo_idle)
  );

  // RAM: registered read address, data only trustworthy the cycle after ram_re.
  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] m_ra_q;
  logic          m_re_q;
  always @(posedge clk) begin
    if (ram_we) mem[ram_wa] <= ram_di;
    m_re_q <= ram_re;
    if (ram_re) m_ra_q <= ram_ra;
  end
  assign ram_dout = m_re_q ? mem[m_ra_q] : JUNK;

  // ---------------- scoreboard state ----------------
  logic [DW-1:0] exp_q[$];
  int            n_acc, n_iss, n_pop;
  bit            prev_re, m_rstn_q, last_acc;
  int            n_dut_acc, n_dut_pop;
  bit            last_dut_acc, last_dut_prdy;
  logic [DW-1:0] last_pop_pd;
  int            n_vec, n_err;

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chkw(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chki(input string tag, input int obs, input int exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] rand_word();
    logic [DW-1:0] w;
    for (int i = 0; i < DW/32; i++) w[i*32 +: 32] = $urandom;
    return w;
  endfunction

  // One clock: check outputs at the falling edge against the count/queue model,
  // then advance the model with this cycle's handshakes.
  task automatic tick();
    int   ram_cnt_m, occ_m, ob_m;
    logic exp_prdy, exp_vld, exp_re, acc, pop;
    @(negedge clk);
    ram_cnt_m = n_acc - n_iss;
    occ_m     = n_iss - n_pop;
    ob_m      = occ_m - int'(prev_re);
    exp_prdy  = m_rstn_q && (ram_cnt_m != DEPTH);
    exp_vld   = (ob_m != 0);
    pop       = exp_vld && rd_prdy;
    acc       = wr_pvld && exp_prdy;
    exp_re    = (ram_cnt_m != 0) && ((occ_m - int'(pop)) < 2);
    chk1("wr_prdy", wr_prdy, exp_prdy);
    chk1("rd_pvld", rd_pvld, exp_vld);
    if (exp_vld) chkw("rd_pd", rd_pd, exp_q[0]);
    chk1("ram_we", ram_we, acc);
    if (acc) begin
      chkw("ram_wa", DW'(ram_wa), DW'(n_acc % DEPTH));
      chkw("ram_di", ram_di, wr_pd);
    end
    chk1("ram_re", ram_re, exp_re);
    if (exp_re) chkw("ram_ra", DW'(ram_ra), DW'(n_iss % DEPTH));
    chk1("fifo_idle", fifo_idle, exp_q.size() == 0);
    last_dut_prdy = wr_prdy;
    last_dut_acc  = wr_pvld && wr_prdy;
    if (last_dut_acc) n_dut_acc++;
    if (rd_pvld && rd_prdy) begin
      n_dut_pop++;
      last_pop_pd = rd_pd;
    end
    if (acc) begin
      exp_q.push_back(wr_pd);
      n_acc++;
    end
    if (pop) begin
      void'(exp_q.pop_front());
      n_pop++;
    end
    prev_re  = exp_re;
    if (exp_re) n_iss++;
    last_acc = acc;
    @(posedge clk);
    m_rstn_q = rstn;
    #1;
  endtask

  task automatic do_reset(input int n);
    rstn    = 1'b0;
    wr_pvld = 1'b0;
    rd_prdy = 1'b0;
    repeat (n) @(posedge clk);
    m_rstn_q = 1'b0;
    #1;
    exp_q.delete();
    n_acc = 0; n_iss = 0; n_pop = 0;
    prev_re = 1'b0;
    @(negedge clk);
    chk1("rst_wr_prdy", wr_prdy, 1'b0);
    chk1("rst_rd_pvld", rd_pvld, 1'b0);
    chk1("rst_ram_we", ram_we, 1'b0);
    chk1("rst_ram_re", ram_re, 1'b0);
    chkw("rst_ram_wa", DW'(ram_wa), '0);
    chkw("rst_ram_ra", DW'(ram_ra), '0);
    chk1("rst_fifo_idle", fifo_idle, 1'b1);
    @(posedge clk);
    m_rstn_q = 1'b0;
    #1;
    rstn = 1'b1;
  endtask

  task automatic drain();
    wr_pvld = 1'b0;
    rd_prdy = 1'b1;
    for (int k = 0; k < 700; k++) begin
      if (exp_q.size() == 0) break;
      tick();
    end
    chki("drain_empty", exp_q.size(), 0);
    chk1("drain_idle", fifo_idle, 1'b1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- directed steps ----------------
  initial begin
    logic [DW-1:0] a5, fresh;
    int base;
    rstn = 1'b0; wr_pvld = 1'b0; wr_pd = '0; rd_prdy = 1'b0;
    n_vec = 0; n_err = 0; n_dut_acc = 0; n_dut_pop = 0;
    m_rstn_q = 1'b0; prev_re = 1'b0; last_acc = 1'b0;
    do_reset(3);

    // Single-word latency
    tick();
    a5 = {64{8'hA5}};
    wr_pvld = 1'b1; wr_pd = a5; rd_prdy = 1'b1;
    tick();
    chk1("lat_re_t1", ram_re, 1'b1);
    chkw("lat_ra_t1", DW'(ram_ra), '0);
    wr_pvld = 1'b0;
    tick();
    chk1("lat_vld_t2", rd_pvld, 1'b0);
    tick();
    chk1("lat_vld_t3", rd_pvld, 1'b1);
    chkw("lat_pd_t3", rd_pd, a5);
    tick();
    chk1("lat_idle_t4", fifo_idle, 1'b1);

    // Streaming with pointer wrap
    base = n_dut_pop;
    wr_pvld = 1'b1; rd_prdy = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      wr_pd = {16{i}};
      tick();
    end
    chki("stream_pops", n_dut_pop - base, 997);
    drain();

    // Fill under backpressure
    base = n_dut_acc;
    wr_pvld = 1'b1; rd_prdy = 1'b0; wr_pd = rand_word();
    for (int c = 0; c < 700; c++) begin
      tick();
      if (!last_dut_prdy) break;
      if (last_acc) wr_pd = rand_word();
    end
    chki("fill_accepted", n_dut_acc - base, DEPTH + 2);
    repeat (4) tick();
    // Full: pop and pending write in the same cycle
    rd_prdy = 1'b1;
    tick();
    chk1("full_pop_no_acc", last_dut_acc, 1'b0);
    tick();
    chk1("full_next_acc", last_dut_acc, 1'b1);
    drain();

    // Random backpressure with continuous writes
    wr_pvld = 1'b1; wr_pd = rand_word();
    for (int c = 0; c < 2000; c++) begin
      rd_prdy = 1'($urandom_range(0, 1));
      tick();
      if (last_acc) wr_pd = rand_word();
    end
    for (int k = 0; k < 600 && !last_acc; k++) begin
      rd_prdy = 1'b1;
      tick();
    end
    drain();

    // Reset with buffer and in-flight read occupied
    wr_pvld = 1'b1; rd_prdy = 1'b0; wr_pd = rand_word();
    for (int c = 0; c < 50; c++) begin
      tick();
      if (last_acc) wr_pd = rand_word();
      if (prev_re && (n_iss - n_pop) == 2) break;
    end
    do_reset(1);
    tick();
    fresh = rand_word();
    wr_pvld = 1'b1; wr_pd = fresh; rd_prdy = 1'b1;
    tick();
    base = n_dut_pop;
    drain();
    chki("post_rst_pops", n_dut_pop - base, 1);
    chkw("post_rst_word", last_pop_pd, fresh);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
